// File: rtl/csr_pkg.sv
// Shared CSR address map, mcountinhibit bit positions and address-class helpers
// for the machine-mode CSR storage block.
package csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MISA          = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID       = 12'hF14;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE         = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET       = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH      = 12'hC82;

  localparam int unsigned MCOUNTINHIBIT_CY = 0;
  localparam int unsigned MCOUNTINHIBIT_IR = 2;

  // True for every address that returns defined data on a read.
  function automatic logic csr_readable(input logic [CSR_ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      CSR_MISA, CSR_MHARTID, CSR_MCOUNTINHIBIT, CSR_MSCRATCH,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // True for addresses backed by writable storage (misa is WARL and excluded).
  function automatic logic csr_writable(input logic [CSR_ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      CSR_MCOUNTINHIBIT, CSR_MSCRATCH,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Read/write/retire bus between the pipeline (master) and the CSR regfile (slave).
interface csr_regfile_if #(
  parameter int unsigned WIDTH = 32
);
  logic [11:0]      csr_raddr_i;
  logic             csr_re_i;
  logic [WIDTH-1:0] csr_rdata_o;
  logic             rd_illegal_o;
  logic [11:0]      csr_waddr_i;
  logic             csr_we_i;
  logic [WIDTH-1:0] csr_wdata_i;
  logic             wr_illegal_o;
  logic             retire_i;

  modport master (
    output csr_raddr_i, csr_re_i, csr_waddr_i, csr_we_i, csr_wdata_i, retire_i,
    input  csr_rdata_o, rd_illegal_o, wr_illegal_o
  );

  modport slave (
    input  csr_raddr_i, csr_re_i, csr_waddr_i, csr_we_i, csr_wdata_i, retire_i,
    output csr_rdata_o, rd_illegal_o, wr_illegal_o
  );
endinterface

// File: rtl/csr_counter64.sv
// Double-width counter with independently writable halves; a write to a half
// always beats the increment/carry that would otherwise land on that half.
module csr_counter64 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               wr_lo_i,
  input  logic               wr_hi_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [2*WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             carry;

  // Low-half write suppresses both increment and carry; high-half write
  // lets the low half count but swallows its carry.
  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    carry = inc_i && (lo_q == {WIDTH{1'b1}});

    if (wr_lo_i) begin
      lo_d = wdata_i;
    end else begin
      lo_d = lo_q + WIDTH'(inc_i);
    end

    if (wr_hi_i) begin
      hi_d = wdata_i;
    end else if (!wr_lo_i) begin
      hi_d = hi_q + WIDTH'(carry);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mscratch, mcountinhibit, mcycle/minstret with user
// shadows, identity CSRs, and illegal-access flags for the trap logic.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] HART_ID    = '0,
  parameter logic [WIDTH-1:0] MISA_VALUE = WIDTH'(32'h4000_0100)
) (
  input logic           clk_i,
  input logic           reset_n_i,
  csr_regfile_if.slave  bus
);

  localparam int unsigned CNT_W = 2 * WIDTH;

  logic [WIDTH-1:0] mscratch_q, mscratch_d;
  logic             cy_inh_q, cy_inh_d;
  logic             ir_inh_q, ir_inh_d;

  logic             wr_ro_space;
  logic             wr_legal;
  logic             wr_en;

  logic             mcycle_wr_lo, mcycle_wr_hi;
  logic             minstret_wr_lo, minstret_wr_hi;
  logic             mcycle_inc, minstret_inc;
  logic [CNT_W-1:0] mcycle, minstret;

  logic [WIDTH-1:0] inhibit_rd;
  logic [WIDTH-1:0] rdata;

  // Write decode: the top address quadrant is read-only by construction.
  always_comb begin
    wr_ro_space = (bus.csr_waddr_i[11:10] == 2'b11);
    wr_legal    = !wr_ro_space && csr_writable(bus.csr_waddr_i);
    wr_en       = bus.csr_we_i && wr_legal;
  end

  assign bus.wr_illegal_o = bus.csr_we_i && !wr_legal && (bus.csr_waddr_i != CSR_MISA);
  assign bus.rd_illegal_o = bus.csr_re_i && !csr_readable(bus.csr_raddr_i);

  // Plain storage registers; inhibit changes only affect the following cycle.
  always_comb begin
    mscratch_d = mscratch_q;
    cy_inh_d   = cy_inh_q;
    ir_inh_d   = ir_inh_q;
    if (wr_en && (bus.csr_waddr_i == CSR_MSCRATCH)) begin
      mscratch_d = bus.csr_wdata_i;
    end
    if (wr_en && (bus.csr_waddr_i == CSR_MCOUNTINHIBIT)) begin
      cy_inh_d = bus.csr_wdata_i[MCOUNTINHIBIT_CY];
      ir_inh_d = bus.csr_wdata_i[MCOUNTINHIBIT_IR];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mscratch_q <= '0;
      cy_inh_q   <= 1'b0;
      ir_inh_q   <= 1'b0;
    end else begin
      mscratch_q <= mscratch_d;
      cy_inh_q   <= cy_inh_d;
      ir_inh_q   <= ir_inh_d;
    end
  end

  // Counter strobes; a minstret low write drops a coincident retire inside the counter.
  always_comb begin
    mcycle_wr_lo   = wr_en && (bus.csr_waddr_i == CSR_MCYCLE);
    mcycle_wr_hi   = wr_en && (bus.csr_waddr_i == CSR_MCYCLEH);
    minstret_wr_lo = wr_en && (bus.csr_waddr_i == CSR_MINSTRET);
    minstret_wr_hi = wr_en && (bus.csr_waddr_i == CSR_MINSTRETH);
    mcycle_inc     = !cy_inh_q;
    minstret_inc   = bus.retire_i && !ir_inh_q;
  end

  csr_counter64 #(.WIDTH(WIDTH)) u_mcycle (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (mcycle_inc),
    .wr_lo_i   (mcycle_wr_lo),
    .wr_hi_i   (mcycle_wr_hi),
    .wdata_i   (bus.csr_wdata_i),
    .count_o   (mcycle)
  );

  csr_counter64 #(.WIDTH(WIDTH)) u_minstret (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (minstret_inc),
    .wr_lo_i   (minstret_wr_lo),
    .wr_hi_i   (minstret_wr_hi),
    .wdata_i   (bus.csr_wdata_i),
    .count_o   (minstret)
  );

  // Zero-latency read mux of registered state; unmapped addresses read zero.
  always_comb begin
    inhibit_rd                   = '0;
    inhibit_rd[MCOUNTINHIBIT_CY] = cy_inh_q;
    inhibit_rd[MCOUNTINHIBIT_IR] = ir_inh_q;

    rdata = '0;
    case (bus.csr_raddr_i)
      CSR_MISA:                   rdata = MISA_VALUE;
      CSR_MHARTID:                rdata = HART_ID;
      CSR_MCOUNTINHIBIT:          rdata = inhibit_rd;
      CSR_MSCRATCH:               rdata = mscratch_q;
      CSR_MCYCLE,   CSR_CYCLE:    rdata = mcycle[WIDTH-1:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata = mcycle[CNT_W-1:WIDTH];
      CSR_MINSTRET, CSR_INSTRET:  rdata = minstret[WIDTH-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[CNT_W-1:WIDTH];
      default:                    rdata = '0;
    endcase
  end

  assign bus.csr_rdata_o = rdata;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed plus randomized bench for csr_regfile against a 64-bit arithmetic
// reference model of the CSR state.
module tb_csr_regfile;

  logic clk;
  logic rst_n;

  csr_regfile_if #(.WIDTH(32)) bus ();

  csr_regfile #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_scratch;
  logic        m_cy, m_ir;
  logic [31:0] save_c, save_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [11:0] a);
    case (a)
      12'h301:          return 32'h4000_0100;
      12'hF14:          return 32'h0;
      12'h320:          return {29'b0, m_ir, 1'b0, m_cy};
      12'h340:          return m_scratch;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default:          return 32'h0;
    endcase
  endfunction

  function automatic logic exp_rd_ill(input logic re, input logic [11:0] a);
    return re && !(a inside {12'h301, 12'hF14, 12'h320, 12'h340, 12'hB00, 12'hB80,
                             12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82});
  endfunction

  function automatic logic exp_wr_ill(input logic we, input logic [11:0] a);
    return we && !(a inside {12'h301, 12'h320, 12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82});
  endfunction

  // Reference update: counters as 64-bit values, half-writes spliced in.
  function automatic void model_step();
    logic [63:0] nc, ni;
    logic        inc_c, inc_r;
    if (!rst_n) begin
      m_cycle = '0; m_instret = '0; m_scratch = '0; m_cy = 1'b0; m_ir = 1'b0;
      return;
    end
    inc_c = !m_cy;
    inc_r = bus.retire_i && !m_ir;
    nc = m_cycle + 64'(inc_c);
    ni = m_instret + 64'(inc_r);
    if (bus.csr_we_i) begin
      case (bus.csr_waddr_i)
        12'h340: m_scratch = bus.csr_wdata_i;
        12'h320: begin m_cy = bus.csr_wdata_i[0]; m_ir = bus.csr_wdata_i[2]; end
        12'hB00: nc = {m_cycle[63:32], bus.csr_wdata_i};
        12'hB80: nc = {bus.csr_wdata_i, m_cycle[31:0] + 32'(inc_c)};
        12'hB02: ni = {m_instret[63:32], bus.csr_wdata_i};
        12'hB82: ni = {bus.csr_wdata_i, m_instret[31:0] + 32'(inc_r)};
        default: ;
      endcase
    end
    m_cycle   = nc;
    m_instret = ni;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_rd(input logic [11:0] a, input logic re);
    bus.csr_raddr_i = a;
    bus.csr_re_i    = re;
  endtask

  task automatic set_wr(input logic we, input logic [11:0] a, input logic [31:0] d);
    bus.csr_we_i    = we;
    bus.csr_waddr_i = a;
    bus.csr_wdata_i = d;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    set_rd(a, 1'b1);
    #1;
    chk(tag, bus.csr_rdata_o, exp);
  endtask

  initial begin
    logic [11:0] addrs[10];
    addrs = '{12'h320, 12'h340, 12'hB00, 12'hB80, 12'hB02,
              12'hB82, 12'h301, 12'hC00, 12'hF14, 12'h7C0};

    rst_n = 1'b0;
    bus.retire_i = 1'b0;
    set_rd(12'h0, 1'b0);
    set_wr(1'b0, 12'h0, 32'h0);

    // 1: reset and identity reads
    tick(); tick();
    rst_n = 1'b1;
    rd("reset_mscratch", 12'h340, 32'h0);
    rd("mhartid",        12'hF14, 32'h0);
    rd("misa",           12'h301, 32'h4000_0100);
    rd("mcycle_first",   12'hB00, 32'h0);
    chk("reset_rd_ill",  32'(bus.rd_illegal_o), 32'h0);
    tick();
    rd("mcycle_second",  12'hB00, 32'h1);

    // 2: same-cycle read sees old value
    set_wr(1'b1, 12'h340, 32'hDEAD_BEEF);
    rd("scratch_old", 12'h340, 32'h0);
    chk("scratch_wr_ill", 32'(bus.wr_illegal_o), 32'h0);
    tick();
    set_wr(1'b0, 12'h0, 32'h0);
    rd("scratch_new", 12'h340, 32'hDEAD_BEEF);

    // 3a: high write discards low carry
    set_wr(1'b1, 12'hB00, 32'hFFFF_FFFF); tick();
    set_wr(1'b1, 12'hB80, 32'h0000_0005); tick();
    set_wr(1'b0, 12'h0, 32'h0);
    rd("carry_hi0", 12'hB80, 32'h5);
    rd("carry_lo0", 12'hB00, 32'h0);
    tick();
    rd("carry_lo1", 12'hB00, 32'h1);
    rd("carry_hi1", 12'hB80, 32'h5);

    // 3b: full wrap
    set_wr(1'b1, 12'hB80, 32'hFFFF_FFFF); tick();
    set_wr(1'b1, 12'hB00, 32'hFFFF_FFFF); tick();
    set_wr(1'b0, 12'h0, 32'h0);
    rd("preset_lo", 12'hB00, 32'hFFFF_FFFF);
    rd("preset_hi", 12'hC80, 32'hFFFF_FFFF);
    tick();
    rd("wrap_lo", 12'hC00, 32'h0);
    rd("wrap_hi", 12'hB80, 32'h0);

    // 4: inhibit freezes both counters
    set_wr(1'b1, 12'h320, 32'hFFFF_FFFF); tick();
    set_wr(1'b0, 12'h0, 32'h0);
    rd("inhibit_rd", 12'h320, 32'h5);
    save_c = m_cycle[31:0];
    save_i = m_instret[31:0];
    for (int i = 0; i < 10; i++) begin
      bus.retire_i = (i < 3);
      tick();
    end
    bus.retire_i = 1'b0;
    rd("frozen_cycle",   12'hB00, save_c);
    rd("frozen_instret", 12'hB02, save_i);
    set_wr(1'b1, 12'h320, 32'h0); tick();
    set_wr(1'b0, 12'h0, 32'h0);
    bus.retire_i = 1'b1;
    tick(); tick(); tick();
    bus.retire_i = 1'b0;
    rd("instret_plus3", 12'hC02, save_i + 32'd3);

    // 5: write beats retire
    bus.retire_i = 1'b1;
    set_wr(1'b1, 12'hB02, 32'd100); tick();
    bus.retire_i = 1'b0;
    set_wr(1'b0, 12'h0, 32'h0);
    rd("wr_beats_retire", 12'hB02, 32'd100);

    // 6: illegal accesses and reset priority
    set_wr(1'b1, 12'hC00, 32'h1234_5678);
    #1;
    chk("wr_ill_c00", 32'(bus.wr_illegal_o), 32'h1);
    save_c = m_cycle[31:0];
    tick();
    set_wr(1'b1, 12'h301, 32'h0);
    rd("cycle_after_ill", 12'hB00, save_c + 32'd1);
    chk("wr_ill_misa", 32'(bus.wr_illegal_o), 32'h0);
    tick();
    set_wr(1'b0, 12'h0, 32'h0);
    rd("misa_kept", 12'h301, 32'h4000_0100);
    rd("rd_unimpl_data", 12'h7C0, 32'h0);
    chk("rd_ill_re1", 32'(bus.rd_illegal_o), 32'h1);
    set_rd(12'h7C0, 1'b0);
    #1;
    chk("rd_ill_re0", 32'(bus.rd_illegal_o), 32'h0);
    rst_n = 1'b0;
    set_wr(1'b1, 12'h340, 32'hCAFE_F00D); tick();
    rst_n = 1'b1;
    set_wr(1'b0, 12'h0, 32'h0);
    rd("reset_beats_wr", 12'h340, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      bus.retire_i = 1'($urandom_range(0, 1));
      set_rd(($urandom_range(0, 3) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)],
             1'($urandom_range(0, 1)));
      set_wr(($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)],
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      #1;
      chk("rnd_rdata",  bus.csr_rdata_o, exp_rdata(bus.csr_raddr_i));
      chk("rnd_rd_ill", 32'(bus.rd_illegal_o), 32'(exp_rd_ill(bus.csr_re_i, bus.csr_raddr_i)));
      chk("rnd_wr_ill", 32'(bus.wr_illegal_o), 32'(exp_wr_ill(bus.csr_we_i, bus.csr_waddr_i)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
